// File: rtl/evg_frame_gen.sv
// 16-bit event/segmented-data stream generator for the GTP TX lane (low byte events, high byte data).
// Define EVG_BEACON_EN to add periodic beacon events (8'h7E) on the event lane.
module evg_frame_gen #(
  parameter int unsigned SEG_BYTES     = 16,
  parameter int unsigned COMMA_PERIOD  = 4,
  parameter int unsigned BEACON_PERIOD = 7
) (
  input  logic                   tx_clk,
  input  logic                   tx_rst,
  input  logic                   ready,
  input  logic [7:0]             ev_code,
  input  logic                   ev_valid,
  output logic                   ev_ready,
  input  logic [7:0]             dbus,
  input  logic [7:0]             seg_addr,
  input  logic [8*SEG_BYTES-1:0] seg_data,
  input  logic                   seg_valid,
  output logic                   seg_ready,
  output logic                   busy,
  output logic [15:0]            tx_data,
  output logic [1:0]             txcharisk
);
  localparam int unsigned CommaW = (COMMA_PERIOD > 1) ? $clog2(COMMA_PERIOD) : 1;
  localparam int unsigned CntW   = $clog2(SEG_BYTES + 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StAddr, StData, StStop, StCsumHi, StCsumLo
  } state_e;

  state_e                 state_q, state_d;
  logic                   run, odd_q;
  logic [CommaW-1:0]      comma_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [8*SEG_BYTES-1:0] buf_q, buf_d;
  logic [7:0]             addr_q, addr_d;
  logic [15:0]            sum_q, sum_d;
  logic                   comma_slot, beacon_slot;
  logic [7:0]             ev_byte, dl_byte;
  logic                   ev_k, dl_k;
  logic [15:0]            tx_data_q;
  logic [1:0]             txcharisk_q;

  assign run        = ready & ~tx_rst;
  assign comma_slot = (comma_q == '0);

`ifdef EVG_BEACON_EN
  localparam int unsigned BeaconW = $clog2(BEACON_PERIOD);
  logic [BeaconW-1:0] beacon_q;

  // A beacon colliding with a comma is dropped, not deferred.
  assign beacon_slot = (beacon_q == BeaconW'(BEACON_PERIOD - 1)) & ~comma_slot;

  always_ff @(posedge tx_clk) begin
    if (!run || beacon_q == BeaconW'(BEACON_PERIOD - 1)) beacon_q <= '0;
    else                                                   beacon_q <= beacon_q + BeaconW'(1);
  end
`else
  assign beacon_slot = 1'b0;
`endif

  assign ev_ready  = run & ~comma_slot & ~beacon_slot;
  assign seg_ready = run & (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign tx_data   = tx_data_q;
  assign txcharisk = txcharisk_q;

  always_comb begin
    ev_byte = 8'h00;
    ev_k    = 1'b0;
    if (comma_slot) begin
      ev_byte = 8'hBC;
      ev_k    = 1'b1;
    end else if (beacon_slot) begin
      ev_byte = 8'h7E;
    end else if (ev_valid && ev_ready) begin
      ev_byte = ev_code;
    end
  end

  // Frame FSM advances only on odd words; even words carry the distributed bus.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    dl_byte = 8'h00;
    dl_k    = 1'b0;
    if (!odd_q) begin
      dl_byte = dbus;
    end else begin
      unique case (state_q)
        StIdle: ;
        StStart: begin
          dl_byte = 8'h5C;
          dl_k    = 1'b1;
          state_d = StAddr;
        end
        StAddr: begin
          dl_byte = addr_q;
          cnt_d   = '0;
          state_d = StData;
        end
        StData: begin
          dl_byte = buf_q[7:0];
          buf_d   = buf_q >> 8;
          sum_d   = sum_q + {8'h00, buf_q[7:0]};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(SEG_BYTES - 1)) state_d = StStop;
        end
        StStop: begin
          dl_byte = 8'h3C;
          dl_k    = 1'b1;
          state_d = StCsumHi;
        end
        StCsumHi: begin
          dl_byte = ~sum_q[15:8];
          state_d = StCsumLo;
        end
        StCsumLo: begin
          dl_byte = ~sum_q[7:0];
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    // Accept only happens in StIdle, so it never collides with the case above.
    if (seg_valid && seg_ready) begin
      state_d = StStart;
      buf_d   = seg_data;
      addr_d  = seg_addr;
      sum_d   = {8'h00, seg_addr};
    end
  end

  always_ff @(posedge tx_clk) begin
    if (!run) begin
      state_q     <= StIdle;
      odd_q       <= 1'b0;
      comma_q     <= '0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      txcharisk_q <= '0;
    end else begin
      state_q     <= state_d;
      odd_q       <= ~odd_q;
      comma_q     <= (comma_q == CommaW'(COMMA_PERIOD - 1)) ? '0 : comma_q + CommaW'(1);
      cnt_q       <= cnt_d;
      tx_data_q   <= {dl_byte, ev_byte};
      txcharisk_q <= {dl_k, ev_k};
    end
  end

  // Payload holding registers; contents are ignored whenever the FSM is idle.
  always_ff @(posedge tx_clk) begin
    buf_q  <= buf_d;
    addr_q <= addr_d;
    sum_q  <= sum_d;
  end

endmodule
